// File: rtl/serv_pkg.sv
// Shared types and constants for the bit-serial execution sequencer.
package serv_pkg;

    localparam int               CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        RFREQ,
        INIT,
        MEMWAIT,
        EXEC
    } state_t;

endpackage

// File: rtl/serv_seq_cnt.sv
// Serial-step bit counter: advances only when enabled, flags the last step of a 32-step phase.
module serv_seq_cnt
    import serv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Phases are always exactly 32 steps, so the natural 31->0 wrap lands on a phase boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 5'd1;
        end
    end

    assign done = (cnt == CNT_LAST);

endmodule

// File: rtl/serv_seq_ctrl.sv
// Execution sequencer: fetch handshake, decode strobe, two-phase op chaining and 32-step counter.
//  state   | meaning
//  FETCH   | ibus request outstanding, waiting for ack
//  DECODE  | decoder outputs valid, first register read requested
//  RFREQ   | wait for register file to start streaming
//  INIT    | first phase of two-phase op (operands/address), 32 steps
//  MEMWAIT | data bus transaction, counter frozen
//  EXEC    | execute/retire phase, 32 steps, PC update
module serv_seq_ctrl
    import serv_pkg::*;
#(
    parameter bit WITH_CSR = 1'b1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    output logic             o_ibus_cyc,
    input  logic             i_ibus_ack,
    output logic             o_dec_en,
    input  logic             i_branch_op,
    input  logic             i_cond_branch,
    input  logic             i_mem_op,
    input  logic             i_shift_op,
    input  logic             i_slt_op,
    input  logic             i_rd_op,
    input  logic             i_e_op,
    input  logic             i_alu_cmp,
    input  logic             i_mem_misalign,
    output logic             o_rf_rreq,
    input  logic             i_rf_ready,
    output logic             o_dbus_cyc,
    input  logic             i_dbus_ack,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt_en,
    output logic             o_init,
    output logic             o_rd_wen,
    output logic             o_pc_en,
    output logic             o_take_branch,
    output logic             o_trap
);

    state_t state, state_nxt;
    logic   second_rd, second_rd_nxt;
    logic   trap_r, trap_nxt;
    logic   take_branch_nxt;
    logic   ibus_cyc, dbus_cyc;
    logic   cnt_en, cnt_done;
    logic   two_phase;

    assign two_phase = i_branch_op | i_shift_op | i_slt_op | i_mem_op;

    serv_seq_cnt u_cnt (
        .clk   (clk),
        .rst_n (i_rst_n),
        .en    (cnt_en),
        .cnt   (o_cnt),
        .done  (cnt_done)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= FETCH;
            second_rd     <= 1'b0;
            trap_r        <= 1'b0;
            o_take_branch <= 1'b0;
        end else begin
            state         <= state_nxt;
            second_rd     <= second_rd_nxt;
            trap_r        <= trap_nxt;
            o_take_branch <= take_branch_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        second_rd_nxt   = second_rd;
        trap_nxt        = trap_r;
        take_branch_nxt = o_take_branch;
        ibus_cyc        = 1'b0;
        dbus_cyc        = 1'b0;
        o_rf_rreq       = 1'b0;
        cnt_en          = 1'b0;
        o_init          = 1'b0;
        o_rd_wen        = 1'b0;
        o_pc_en         = 1'b0;
        o_trap          = 1'b0;
        case (state)
            FETCH: begin
                ibus_cyc = 1'b1;
                if (i_ibus_ack) state_nxt = DECODE;
            end
            DECODE: begin
                o_rf_rreq = 1'b1;
                state_nxt = RFREQ;
                if (WITH_CSR && i_e_op) begin
                    o_trap   = 1'b1;
                    trap_nxt = 1'b1;
                end
            end
            RFREQ: begin
                o_rf_rreq = 1'b1;
                if (i_rf_ready) begin
                    state_nxt = (second_rd || trap_r || !two_phase) ? EXEC : INIT;
                end
            end
            INIT: begin
                o_init = 1'b1;
                cnt_en = 1'b1;
                if (cnt_done) begin
                    if (i_branch_op) take_branch_nxt = !i_cond_branch | i_alu_cmp;
                    if (i_mem_op) begin
                        // A misaligned access never reaches the bus; EXEC only moves the PC.
                        if (i_mem_misalign) begin
                            o_trap    = 1'b1;
                            trap_nxt  = 1'b1;
                            state_nxt = EXEC;
                        end else begin
                            state_nxt = MEMWAIT;
                        end
                    end else begin
                        second_rd_nxt = 1'b1;
                        state_nxt     = RFREQ;
                    end
                end
            end
            MEMWAIT: begin
                dbus_cyc = 1'b1;
                if (i_dbus_ack) state_nxt = EXEC;
            end
            EXEC: begin
                cnt_en   = 1'b1;
                o_pc_en  = 1'b1;
                o_rd_wen = i_rd_op & !trap_r;
                if (cnt_done) begin
                    state_nxt       = FETCH;
                    second_rd_nxt   = 1'b0;
                    trap_nxt        = 1'b0;
                    take_branch_nxt = 1'b0;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Bus requests drop the moment reset asserts, not at the next edge.
    assign o_ibus_cyc = ibus_cyc & i_rst_n;
    assign o_dbus_cyc = dbus_cyc & i_rst_n;
    assign o_dec_en   = o_ibus_cyc & i_ibus_ack;
    assign o_cnt_en   = cnt_en;

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// Scoreboard bench for serv_seq_ctrl: directed instructions, per-instruction retire records checked.
module tb_serv_seq_ctrl;

    typedef struct {
        string nm;
        bit    br, cb, mem, sh, slt, rd, e, cmp, mis;
        int    iw, dw;
        int    x_ibus, x_init, x_dbus, x_rd1, x_rd0, x_tb, x_trap1, x_trap0;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ibus_ack, dbus_ack, rf_ready;
    logic       branch_op, cond_branch, mem_op, shift_op, slt_op, rd_op, e_op, alu_cmp, mem_misalign;
    logic       ibus_cyc, dec_en, rf_rreq, dbus_cyc, cnt_en, init, rd_wen, pc_en, take_branch, trap;
    logic [4:0] cnt;
    logic       ibus_cyc0, dec_en0, rf_rreq0, dbus_cyc0, cnt_en0, init0, rd_wen0, pc_en0, take_branch0, trap0;
    logic [4:0] cnt0;

    serv_seq_ctrl #(.WITH_CSR(1'b1)) dut (
        .clk(clk), .i_rst_n(rst_n), .o_ibus_cyc(ibus_cyc), .i_ibus_ack(ibus_ack), .o_dec_en(dec_en),
        .i_branch_op(branch_op), .i_cond_branch(cond_branch), .i_mem_op(mem_op), .i_shift_op(shift_op),
        .i_slt_op(slt_op), .i_rd_op(rd_op), .i_e_op(e_op), .i_alu_cmp(alu_cmp), .i_mem_misalign(mem_misalign),
        .o_rf_rreq(rf_rreq), .i_rf_ready(rf_ready), .o_dbus_cyc(dbus_cyc), .i_dbus_ack(dbus_ack),
        .o_cnt(cnt), .o_cnt_en(cnt_en), .o_init(init), .o_rd_wen(rd_wen), .o_pc_en(pc_en),
        .o_take_branch(take_branch), .o_trap(trap)
    );

    serv_seq_ctrl #(.WITH_CSR(1'b0)) dut0 (
        .clk(clk), .i_rst_n(rst_n), .o_ibus_cyc(ibus_cyc0), .i_ibus_ack(ibus_ack), .o_dec_en(dec_en0),
        .i_branch_op(branch_op), .i_cond_branch(cond_branch), .i_mem_op(mem_op), .i_shift_op(shift_op),
        .i_slt_op(slt_op), .i_rd_op(rd_op), .i_e_op(e_op), .i_alu_cmp(alu_cmp), .i_mem_misalign(mem_misalign),
        .o_rf_rreq(rf_rreq0), .i_rf_ready(rf_ready), .o_dbus_cyc(dbus_cyc0), .i_dbus_ack(dbus_ack),
        .o_cnt(cnt0), .o_cnt_en(cnt_en0), .o_init(init0), .o_rd_wen(rd_wen0), .o_pc_en(pc_en0),
        .o_take_branch(take_branch0), .o_trap(trap0)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    vec_t cur;
    bit   go = 1'b0;
    int   n_ret = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor accumulators, one retire record per instruction.
    int a_ibus, a_dec, a_init, a_dbus, a_mem, a_steps, a_rd1, a_rd0, a_tb, a_tbf, a_tr1, a_tr0, a_ov;

    task automatic clr_acc();
        a_ibus = 0; a_dec = 0; a_init = 0; a_dbus = 0; a_mem = 0; a_steps = 0; a_rd1 = 0;
        a_rd0 = 0; a_tb = 0; a_tbf = 0; a_tr1 = 0; a_tr0 = 0; a_ov = 0;
    endtask

    initial clr_acc();

    always @(negedge clk) begin
        if (!rst_n) begin
            clr_acc();
        end else begin
            a_ibus  += int'(ibus_cyc);
            a_dec   += int'(dec_en);
            a_init  += int'(init);
            a_dbus  += int'(dbus_cyc);
            a_mem   += int'(dbus_cyc && cnt != 5'd0);
            a_steps += int'(pc_en);
            a_rd1   += int'(rd_wen);
            a_rd0   += int'(rd_wen0);
            a_tb    += int'(take_branch && pc_en);
            a_tbf   += int'(take_branch && ibus_cyc);
            a_tr1   += int'(trap);
            a_tr0   += int'(trap0);
            a_ov    += int'(ibus_cyc && dbus_cyc) + int'(ibus_cyc0 && dbus_cyc0);
            if (pc_en && cnt == 5'd31) begin
                n_ret++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL retire_unexpected: got a retirement, expected none");
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    chk({e.nm, ".ibus_cycles"}, a_ibus, e.x_ibus);
                    chk({e.nm, ".dec_en"}, a_dec, 1);
                    chk({e.nm, ".init_cycles"}, a_init, e.x_init);
                    chk({e.nm, ".dbus_cycles"}, a_dbus, e.x_dbus);
                    chk({e.nm, ".cnt_moved_in_memwait"}, a_mem, 0);
                    chk({e.nm, ".exec_steps"}, a_steps, 32);
                    chk({e.nm, ".rd_wen_csr1"}, a_rd1, e.x_rd1);
                    chk({e.nm, ".rd_wen_csr0"}, a_rd0, e.x_rd0);
                    chk({e.nm, ".take_branch_exec"}, a_tb, e.x_tb);
                    chk({e.nm, ".take_branch_fetch"}, a_tbf, 0);
                    chk({e.nm, ".trap_csr1"}, a_tr1, e.x_trap1);
                    chk({e.nm, ".trap_csr0"}, a_tr0, e.x_trap0);
                    chk({e.nm, ".bus_overlap"}, a_ov, 0);
                end
                clr_acc();
            end
        end
    end

    // Bus responders: ibus acks after cur.iw idle cycles, dbus after cur.dw.
    int icnt = 0;
    int dcnt = 0;
    initial begin
        ibus_ack = 1'b0;
        dbus_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ibus_cyc && go) begin
                if (icnt == cur.iw) begin
                    ibus_ack = 1'b1;
                    go = 1'b0;
                    icnt = 0;
                    branch_op = cur.br; cond_branch = cur.cb; mem_op = cur.mem; shift_op = cur.sh;
                    slt_op = cur.slt; rd_op = cur.rd; e_op = cur.e; alu_cmp = cur.cmp;
                    mem_misalign = cur.mis;
                end else begin
                    ibus_ack = 1'b0;
                    icnt++;
                end
            end else begin
                ibus_ack = 1'b0;
                icnt = 0;
            end
            if (dbus_cyc) begin
                if (dcnt == cur.dw) begin
                    dbus_ack = 1'b1;
                    dcnt = 0;
                end else begin
                    dbus_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                dbus_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    task automatic issue(input vec_t v);
        int start;
        exp_q.push_back(v);
        cur = v;
        start = n_ret;
        go = 1'b1;
        for (int i = 0; i < 400 && n_ret == start; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_ret == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no retirement in 400 cycles, expected one", v.nm);
            go = 1'b0;
        end
    endtask

    function automatic vec_t mk(input string nm, input bit br, cb, mem, sh, slt, rd, e, cmp, mis,
                                input int iw, dw, x_ibus, x_init, x_dbus, x_rd1, x_rd0, x_tb,
                                x_trap1, x_trap0);
        vec_t v;
        v.nm = nm; v.br = br; v.cb = cb; v.mem = mem; v.sh = sh; v.slt = slt; v.rd = rd; v.e = e;
        v.cmp = cmp; v.mis = mis; v.iw = iw; v.dw = dw; v.x_ibus = x_ibus; v.x_init = x_init;
        v.x_dbus = x_dbus; v.x_rd1 = x_rd1; v.x_rd0 = x_rd0; v.x_tb = x_tb;
        v.x_trap1 = x_trap1; v.x_trap0 = x_trap0;
        return v;
    endfunction

    vec_t vecs[$];
    int   rd_after;
    bit   hit;

    initial begin
        rst_n = 1'b0;
        rf_ready = 1'b1;
        branch_op = 0; cond_branch = 0; mem_op = 0; shift_op = 0; slt_op = 0;
        rd_op = 0; e_op = 0; alu_cmp = 0; mem_misalign = 0;
        cur = mk("idle", 0,0,0,0,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0);

        repeat (3) @(posedge clk);
        #2;
        chk("rst.ibus_cyc", int'(ibus_cyc), 0);
        chk("rst.dbus_cyc", int'(dbus_cyc), 0);
        chk("rst.rf_rreq", int'(rf_rreq), 0);
        chk("rst.cnt", int'(cnt), 0);
        chk("rst.pc_en", int'(pc_en), 0);
        chk("rst.take_branch", int'(take_branch), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel.ibus_cyc", int'(ibus_cyc), 1);
        chk("rel.cnt", int'(cnt), 0);

        //              name        br cb me sh sl rd e cmp mis iw dw ibus init dbus rd1 rd0 tb tr1 tr0
        vecs.push_back(mk("addi",     0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 3,  0,  0,  32, 32, 0,  0, 0));
        vecs.push_back(mk("beq_t",    1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2,  32, 0,  0,  0,  32, 0, 0));
        vecs.push_back(mk("beq_nt",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  32, 0,  0,  0,  0,  0, 0));
        vecs.push_back(mk("jal",      1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2,  32, 0,  32, 32, 32, 0, 0));
        vecs.push_back(mk("lw",       0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4, 1,  32, 5,  32, 32, 0,  0, 0));
        vecs.push_back(mk("sw_mis",   0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1,  32, 0,  0,  0,  0,  1, 1));
        vecs.push_back(mk("ecall",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0,  0,  0,  0,  0,  1, 0));
        vecs.push_back(mk("ecall_rd", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 2,  0,  0,  0,  32, 0,  1, 0));
        vecs.push_back(mk("sll",      0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1,  32, 0,  32, 32, 0,  0, 0));
        vecs.push_back(mk("slt",      0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1,  32, 0,  32, 32, 0,  0, 0));
        vecs.push_back(mk("lw_0wait", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,  32, 1,  32, 32, 0,  0, 0));
        foreach (vecs[i]) issue(vecs[i]);

        // Abandon an ADDI at EXEC step 17 with an asynchronous reset.
        cur = mk("addi_abort", 0,0,0,0,0,1,0,0,0, 0,0, 0,0,0,0,0,0,0,0);
        go = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (pc_en && cnt == 5'd17) hit = 1'b1;
        end
        chk("abort.reached_cnt17", int'(hit), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.rd_wen", int'(rd_wen), 0);
        chk("abort.pc_en", int'(pc_en), 0);
        chk("abort.cnt_en", int'(cnt_en), 0);
        chk("abort.cnt", int'(cnt), 0);
        chk("abort.ibus_cyc", int'(ibus_cyc), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        go = 1'b0;
        #1;
        chk("abort_rel.ibus_cyc", int'(ibus_cyc), 1);
        chk("abort_rel.cnt", int'(cnt), 0);
        rd_after = 0;
        repeat (5) begin
            @(negedge clk);
            rd_after += int'(rd_wen);
        end
        chk("abort_rel.rd_wen_cycles", rd_after, 0);
        #1;
        // Five idle FETCH cycles already seen by the monitor, plus 1 wait + ack cycle.
        issue(mk("addi_post", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 7, 0, 0, 32, 32, 0, 0, 0));

        chk("exp_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
